// File: rtl/pudding_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pudding_chain_ctrl
//  Description : Configuration daisychain plus committed state register for
//                the analog-control bus. Bits shift into the chain LANES at a
//                time. A commit copies the chain into the state register,
//                gated by a frame counter when STRICT is set. A readback
//                copies the state back into the chain so it can be shifted
//                out MSB-first on dout_o. A one-cycle commit strobe marks an
//                accepted commit, and a sticky error flag marks a rejected
//                one.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module pudding_chain_ctrl #(
    parameter int CHAIN_W = 128,
    parameter int LANES   = 1,
    parameter int TAP_W   = 8,
    parameter bit STRICT  = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  shift_i,
    input  logic [LANES-1:0]                      din_i,
    input  logic                                  transfer_i,
    input  logic                                  dir_i,
    input  logic                                  clr_err_i,
    output logic [TAP_W-1:0]                      chain_tap_o,
    output logic [TAP_W-1:0]                      state_tap_o,
    output logic [CHAIN_W-1:0]                    state_o,
    output logic [LANES-1:0]                      dout_o,
    output logic [$clog2(CHAIN_W/LANES+2)-1:0]    cnt_o,
    output logic                                  frame_full_o,
    output logic                                  state_valid_o,
    output logic                                  commit_o,
    output logic                                  commit_err_o
);

    // Number of shift cycles that make up one complete frame.
    localparam int FRAME = CHAIN_W / LANES;
    // The counter must hold 0..FRAME+1, where FRAME+1 marks an overrun.
    localparam int CNT_W = $clog2(FRAME + 2);

    localparam logic [CNT_W-1:0] c_cnt_frame   = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0] c_cnt_overrun = CNT_W'(FRAME + 1);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    logic [CHAIN_W-1:0] r_chain;
    logic [CHAIN_W-1:0] r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_state_valid;
    logic               r_commit;
    logic               r_commit_err;

    logic [CHAIN_W-1:0] w_chain_shifted;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_frame_match;
    logic               w_commit_req;
    logic               w_commit_ok;
    logic               w_commit_rej;

    // A chain one lane wide is completely replaced by each shift, so there is
    // no older slice to carry along.
    generate
        if (LANES == CHAIN_W) begin : g_shift_whole
            assign w_chain_shifted = din_i;
        end else begin : g_shift_lane
            assign w_chain_shifted = {r_chain[CHAIN_W-LANES-1:0], din_i};
        end
    endgenerate

    // The counter parks at FRAME+1 so any overrun stays visible until the
    // next transfer.
    assign w_cnt_inc     = (r_cnt == c_cnt_overrun) ? r_cnt : (r_cnt + c_cnt_one);
    assign w_frame_match = (r_cnt == c_cnt_frame);

    // Transfer outranks shift. A commit is accepted when the frame is exactly
    // full, or always when STRICT is clear.
    assign w_commit_req  = transfer_i & dir_i;
    assign w_commit_ok   = w_commit_req & ((STRICT == 1'b0) | w_frame_match);
    assign w_commit_rej  = w_commit_req & ~w_commit_ok;

    // Chain: a readback loads it from state, a shift moves it, and a commit
    // leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else if (transfer_i) begin
            if (!dir_i) begin
                r_chain <= r_state;
            end
        end else if (shift_i) begin
            r_chain <= w_chain_shifted;
        end
    end

    // Frame counter: any transfer restarts it, and each shift advances it
    // with saturation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (transfer_i) begin
            r_cnt <= '0;
        end else if (shift_i) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // State register and its valid flag change only on an accepted commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= '0;
            r_state_valid <= 1'b0;
        end else if (w_commit_ok) begin
            r_state       <= r_chain;
            r_state_valid <= 1'b1;
        end
    end

    // Commit strobe: a registered one-cycle pulse for each accepted commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit <= 1'b0;
        end else begin
            r_commit <= w_commit_ok;
        end
    end

    // Sticky error: a rejected commit sets it and wins over a clear request
    // in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_err <= 1'b0;
        end else if (w_commit_rej) begin
            r_commit_err <= 1'b1;
        end else if (clr_err_i) begin
            r_commit_err <= 1'b0;
        end
    end

    assign chain_tap_o   = r_chain[CHAIN_W-1 -: TAP_W];
    assign state_tap_o   = r_state[CHAIN_W-1 -: TAP_W];
    assign state_o       = r_state;
    assign dout_o        = r_chain[CHAIN_W-1 -: LANES];
    assign cnt_o         = r_cnt;
    assign frame_full_o  = w_frame_match;
    assign state_valid_o = r_state_valid;
    assign commit_o      = r_commit;
    assign commit_err_o  = r_commit_err;

endmodule
`default_nettype wire

// File: doc/pudding_chain_ctrl.md
Name: pudding_chain_ctrl

Overview:
- Parametrised successor to the 128-bit PUDDING daisychain/state register pair.
- Configurable chain width, a multi-bit shift lane, and a frame counter that guards commits.
- Adds serial readback output, a commit strobe and a sticky commit-error flag.
- Sits between the ui_in control pins and the analog-control state bus. It loads, commits and reads back the configuration word that drives the analog block.

Parameters:
CHAIN_W, 128, bits in the daisychain and in the state register; must be a multiple of LANES.
LANES, 1, bits shifted per shift cycle (1, 2, 4 or 8).
TAP_W, 8, width of the MSB tap outputs; TAP_W <= CHAIN_W.
STRICT, 1, 1 = commit only allowed after exactly FRAME shifts; 0 = commit always allowed.
Derived: FRAME = CHAIN_W/LANES; CNT_W = $clog2(FRAME+2).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
shift_i  in  1  shift strobe; one LANES-bit shift per cycle while high.
din_i  in  LANES  shift data in.
transfer_i  in  1  transfer strobe; has priority over shift_i.
dir_i  in  1  transfer direction: 1 = chain->state (commit), 0 = state->chain (readback).
clr_err_i  in  1  clears commit_err_o.
chain_tap_o  out  TAP_W  chain[CHAIN_W-1 -: TAP_W].
state_tap_o  out  TAP_W  state[CHAIN_W-1 -: TAP_W].
state_o  out  CHAIN_W  full committed state word.
dout_o  out  LANES  chain[CHAIN_W-1 -: LANES]; serial readback.
cnt_o  out  CNT_W  shifts since the last transfer or reset.
frame_full_o  out  1  cnt_o == FRAME.
state_valid_o  out  1  set by the first successful commit after reset.
commit_o  out  1  one-cycle pulse on a successful commit.
commit_err_o  out  1  sticky flag for a rejected commit.

Behaviour:
- Reset (rst high at a clock edge):
  - chain, state, cnt, state_valid_o, commit_o and commit_err_o all go to 0.
  - Reset overrides every other input in the same cycle.
  - Reset mid-frame discards the partial frame.
- Per-cycle priority is rst > transfer_i > shift_i > idle.
- Shift (shift_i=1, transfer_i=0):
  - chain <= {chain[CHAIN_W-LANES-1:0], din_i}. din_i[LANES-1] lands at bit LANES-1; the oldest data moves toward the MSB.
  - cnt <= cnt+1, saturating at FRAME+1. FRAME+1 means overrun.
- Commit (transfer_i=1, dir_i=1):
  - Accepted if STRICT=0 or cnt==FRAME.
  - When accepted: state <= chain, commit_o=1 on the next cycle, state_valid_o <= 1.
  - When rejected (cnt<FRAME or overrun): state is unchanged, commit_err_o <= 1, commit_o stays 0.
  - In both cases cnt <= 0 and chain is unchanged.
- Readback (transfer_i=1, dir_i=0): chain <= state, cnt <= 0, and state is unchanged. Shifting FRAME times afterwards presents the state word on dout_o MSB-first, one lane per cycle.
- transfer_i and shift_i high together: the transfer executes, the shift is ignored and din_i is discarded.
- commit_o:
  - Registered; high exactly one cycle after each accepted commit.
  - Back-to-back commits produce back-to-back pulses. The second commit is rejected under STRICT, because cnt is 0.
- commit_err_o:
  - Set by a rejected commit; cleared by clr_err_i or rst.
  - If a rejected commit coincides with clr_err_i, the set wins.
- Outputs:
  - All outputs are registered or direct slices of registers; no combinational path from inputs to outputs.
  - chain_tap_o/dout_o/cnt_o change the cycle after a shift; state_tap_o/state_o the cycle after a commit.
- Idle (no strobes): all state holds.

Test Plan:
1. Default parameters: reset, then 128 shifts of bit i = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210[i] (bit 0 first), then commit -> chain_tap_o=8'h08 after shift 128; frame_full_o=1; commit_o pulses once; state_tap_o=8'h08 after commit; state_valid_o=1; cnt_o=0.
2. CHAIN_W=16, LANES=4: shift 4'h1, 4'h2, 4'h3, 4'h4, then commit -> state_o=16'h1234; then readback and 4 shifts of 4'h0 -> dout_o sequence 1, 2, 3, 4 (read before each shift); chain=16'h0000 at the end.
3. STRICT=1, CHAIN_W=16, LANES=4: 3 shifts then commit -> commit_err_o=1, state_o unchanged, cnt_o=0. Then 5 shifts then commit (overrun) -> still rejected. Then clr_err_i -> flag clears next cycle.
4. STRICT=0: 1 shift of 4'hF then commit -> accepted; state_o=16'h000F; commit_o pulses; commit_err_o stays 0.
5. shift_i and transfer_i high together (dir_i=1, cnt=FRAME) -> commit accepted; chain unchanged by din_i. Then rst asserted mid-frame after 2 shifts -> all outputs 0 the next cycle.
6. Random 500-cycle mix of shift/commit/readback/idle/clr_err against a cycle-accurate reference model -> every output matches on every cycle.
